// File: rtl/controller_fsm_pkg.sv
// Shared types and constants for the 16-bit processor control unit.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_HALT;
  endfunction

endpackage

// File: rtl/controller_fsm_if.sv
// Control-unit bus: instruction in, datapath control out.
interface controller_fsm_if #(
  parameter int IW  = 16,
  parameter int DAW = 8,
  parameter int RAW = 4
);
  logic [IW-1:0]  IR_in;
  logic           IR_ld;
  logic           PC_clr;
  logic           PC_up;
  logic [DAW-1:0] D_addr;
  logic           D_wr;
  logic           RF_s;
  logic [RAW-1:0] RF_W_addr;
  logic           RF_W_en;
  logic [RAW-1:0] RF_Ra_addr;
  logic [RAW-1:0] RF_Rb_addr;
  logic [2:0]     ALU_s0;
  logic [3:0]     OutState;
  logic           Illegal;

  modport master (
    input  IR_in,
    output IR_ld, PC_clr, PC_up, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState, Illegal
  );

  modport slave (
    output IR_in,
    input  IR_ld, PC_clr, PC_up, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
           RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState, Illegal
  );
endinterface

// File: rtl/controller_fsm_next_state.sv
// Next-state logic for the fetch/decode/execute sequencer.
// CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt instead of running as NOOP.
module ctrl_next_state
  import ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic [3:0] opcode_i,
  output state_t     state_o
);
  always_comb begin
    state_o = S_INIT;
    unique case (state_i)
      S_INIT:   state_o = S_FETCH;
      S_FETCH:  state_o = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_NOOP:  state_o = S_NOOP;
          OP_STORE: state_o = S_STORE;
          OP_LOAD:  state_o = S_LOAD_A;
          OP_ADD:   state_o = S_ADD;
          OP_SUB:   state_o = S_SUB;
          OP_HALT:  state_o = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:  state_o = S_HALT;
`else
          default:  state_o = S_NOOP;
`endif
        endcase
      end
      S_LOAD_A: state_o = S_LOAD_B;
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_o = S_FETCH;
      S_HALT:   state_o = S_HALT;
      default:  state_o = S_INIT;
    endcase
  end
endmodule

// File: rtl/controller_fsm.sv
// Moore control unit: state register, sticky illegal flag, output decode.
// CTRL_ILLEGAL_TRAP_EN: undefined opcode halts and raises Illegal.
module controller_fsm
  import ctrl_pkg::*;
#(
  parameter int IW  = 16,
  parameter int DAW = 8,
  parameter int RAW = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  controller_fsm_if.master  bus
);
  state_t state_q, state_d;
  logic [3:0] opcode;

  assign opcode = bus.IR_in[IW-1 -: 4];

  ctrl_next_state u_next (
    .state_i  (state_q),
    .opcode_i (opcode),
    .state_o  (state_d)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_INIT;
    else       state_q <= state_d;
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge Clk) begin
    if (Reset) illegal_q <= 1'b0;
    else if (state_q == S_DECODE && !is_legal_op(opcode)) illegal_q <= 1'b1;
  end
  assign bus.Illegal = illegal_q;
`else
  assign bus.Illegal = 1'b0;
`endif

  assign bus.OutState = state_q;

  always_comb begin
    bus.IR_ld      = 1'b0;
    bus.PC_clr     = 1'b0;
    bus.PC_up      = 1'b0;
    bus.D_addr     = '0;
    bus.D_wr       = 1'b0;
    bus.RF_s       = 1'b0;
    bus.RF_W_addr  = '0;
    bus.RF_W_en    = 1'b0;
    bus.RF_Ra_addr = '0;
    bus.RF_Rb_addr = '0;
    bus.ALU_s0     = ALU_PASS;
    case (state_q)
      S_INIT:  bus.PC_clr = 1'b1;
      S_FETCH: begin
        bus.IR_ld = 1'b1;
        bus.PC_up = 1'b1;
      end
      S_STORE: begin
        bus.RF_Ra_addr = bus.IR_in[11:8];
        bus.D_addr     = bus.IR_in[7:0];
        bus.D_wr       = 1'b1;
      end
      // memory read is synchronous, so the address is held across both load states
      S_LOAD_A: bus.D_addr = bus.IR_in[11:4];
      S_LOAD_B: begin
        bus.D_addr    = bus.IR_in[11:4];
        bus.RF_s      = 1'b1;
        bus.RF_W_addr = bus.IR_in[3:0];
        bus.RF_W_en   = 1'b1;
      end
      S_ADD, S_SUB: begin
        bus.RF_Ra_addr = bus.IR_in[11:8];
        bus.RF_Rb_addr = bus.IR_in[7:4];
        bus.RF_W_addr  = bus.IR_in[3:0];
        bus.RF_W_en    = 1'b1;
        bus.ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
    // an instruction cut short by reset must not write anything
    if (Reset) begin
      bus.IR_ld   = 1'b0;
      bus.PC_up   = 1'b0;
      bus.D_wr    = 1'b0;
      bus.RF_W_en = 1'b0;
    end
  end
endmodule

// File: tb/tb_controller_fsm.sv
// Self-checking bench for controller_fsm; expected per-cycle outputs come from an instruction-level model.
module tb_controller_fsm;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  controller_fsm_if #(.IW(16), .DAW(8), .RAW(4)) bus ();
  controller_fsm #(.IW(16), .DAW(8), .RAW(4)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  typedef struct packed {
    logic       ill;
    logic [3:0] st;
    logic       ir_ld, pc_clr, pc_up;
    logic [7:0] d_addr;
    logic       d_wr, rf_s;
    logic [3:0] w_addr;
    logic       w_en;
    logic [3:0] ra, rb;
    logic [2:0] alu;
  } obs_t;

  obs_t exp_q[$];
  logic m_ill = 1'b0;

  function automatic obs_t sample();
    obs_t o;
    o.ill = bus.Illegal;      o.st = bus.OutState;
    o.ir_ld = bus.IR_ld;      o.pc_clr = bus.PC_clr;   o.pc_up = bus.PC_up;
    o.d_addr = bus.D_addr;    o.d_wr = bus.D_wr;       o.rf_s = bus.RF_s;
    o.w_addr = bus.RF_W_addr; o.w_en = bus.RF_W_en;
    o.ra = bus.RF_Ra_addr;    o.rb = bus.RF_Rb_addr;   o.alu = bus.ALU_s0;
    return o;
  endfunction

  function automatic obs_t mk(input int st);
    obs_t r = '0;
    r.st = 4'(st);
    r.ill = m_ill;
    return r;
  endfunction

  // Instruction-level model: expand one instruction into its per-cycle expected outputs.
  function automatic void push_instr(input logic [15:0] ir);
    obs_t r;
    r = mk(1); r.ir_ld = 1'b1; r.pc_up = 1'b1; exp_q.push_back(r);
    exp_q.push_back(mk(2));
    case (ir[15:12])
      4'd0: exp_q.push_back(mk(3));
      4'd1: begin
        r = mk(6); r.ra = ir[11:8]; r.d_addr = ir[7:0]; r.d_wr = 1'b1;
        exp_q.push_back(r);
      end
      4'd2: begin
        r = mk(4); r.d_addr = ir[11:4]; exp_q.push_back(r);
        r.st = 4'd5; r.rf_s = 1'b1; r.w_addr = ir[3:0]; r.w_en = 1'b1;
        exp_q.push_back(r);
      end
      4'd3, 4'd4: begin
        r = mk(ir[15:12] == 4'd3 ? 7 : 8);
        r.ra = ir[11:8]; r.rb = ir[7:4]; r.w_addr = ir[3:0]; r.w_en = 1'b1;
        r.alu = (ir[15:12] == 4'd3) ? 3'd1 : 3'd2;
        exp_q.push_back(r);
      end
      4'd5: exp_q.push_back(mk(9));
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        m_ill = 1'b1;
        exp_q.push_back(mk(9));
`else
        exp_q.push_back(mk(3));
`endif
      end
    endcase
  endfunction

  task automatic test_reset();
    obs_t o, e;
    Reset = 1'b1;
    m_ill = 1'b0;
    @(posedge Clk); @(posedge Clk); @(negedge Clk);
    o = sample(); e = mk(0); e.pc_clr = 1'b1; checks++;
    if (o !== e) begin errors++; $display("FAIL reset_held got %h exp %h", o, e); end
    Reset = 1'b0;
    #1;
    o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_released got %h exp %h", o, e); end
  endtask

  task automatic test_instr(input logic [15:0] ir);
    obs_t o, e;
    int k = 0;
    bus.IR_in = ir;
    push_instr(ir);
    while (exp_q.size() > 0) begin
      @(negedge Clk);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL instr_%h cycle %0d got %h exp %h", ir, k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back(input int n);
    obs_t o, e;
    logic [15:0] ir;
    for (int i = 0; i < n; i++) begin
      ir = 16'($urandom);
      if (ir[15:12] == 4'd5) ir[15:12] = 4'd0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (ir[15:12] > 4'd5) ir[15:12] = ir[15:12] % 4'd5;
`endif
      bus.IR_in = ir;
      push_instr(ir);
      while (exp_q.size() > 0) begin
        @(negedge Clk);
        o = sample(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_%0d_%h got %h exp %h", i, ir, o, e); end
      end
    end
  endtask

  task automatic test_halt(input int n);
    obs_t o, e;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      o = sample(); e = mk(9); checks++;
      if (o !== e) begin errors++; $display("FAIL halt_hold_%0d got %h exp %h", i, o, e); end
    end
  endtask

  task automatic test_reset_mid_add();
    obs_t o, e;
    bus.IR_in = 16'h3123;
    push_instr(16'h3123);
    while (exp_q.size() > 1) begin
      @(negedge Clk);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL mid_add_pre got %h exp %h", o, e); end
    end
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    o = sample(); e = exp_q.pop_front(); e.w_en = 1'b0; checks++;
    if (o !== e) begin errors++; $display("FAIL mid_add_reset got %h exp %h", o, e); end
    m_ill = 1'b0;
    @(negedge Clk);
    o = sample(); e = mk(0); e.pc_clr = 1'b1; checks++;
    if (o !== e) begin errors++; $display("FAIL mid_add_init got %h exp %h", o, e); end
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.IR_in = 16'h0000;
    test_reset();
    test_instr(16'h3123);
    test_instr(16'h20A5);
    test_instr(16'h14C7);
    test_instr(16'h4A6B);
    test_instr(16'h0000);
    test_back_to_back(30);
    test_instr(16'hF000);
`ifdef CTRL_ILLEGAL_TRAP_EN
    test_halt(3);
    test_reset();
`endif
    test_reset_mid_add();
    test_instr(16'h5000);
    test_halt(10);
    test_reset();
    test_instr(16'h3123);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/controller_fsm.md
Name: controller_fsm

Overview:
Control unit for the 16-bit processor. It sits directly downstream of the instruction register and consumes the IR's 16-bit output. It also drives the IR load enable, the PC, the data memory, the register file and the ALU select. It runs a Moore fetch/decode/execute state machine, one instruction at a time.

Parameters:
IW, 16, instruction width
DAW, 8, data-memory address width
RAW, 4, register-file address width

Ports:
Clk  in  1  system clock, all state updates on posedge
Reset  in  1  synchronous, active-high reset
IR_in  in  IW  current instruction from IR outData
IR_ld  out  1  IR load enable, wired to IR Id
PC_clr  out  1  clear program counter
PC_up  out  1  increment program counter
D_addr  out  DAW  data-memory address
D_wr  out  1  data-memory write enable
RF_s  out  1  RF write-data mux select: 1 = memory, 0 = ALU
RF_W_addr  out  RAW  RF write address
RF_W_en  out  1  RF write enable
RF_Ra_addr  out  RAW  RF read port A address
RF_Rb_addr  out  RAW  RF read port B address
ALU_s0  out  3  ALU op: 0 = pass A, 1 = A+B, 2 = A-B
OutState  out  4  current state code, for debug display
Illegal  out  1  sticky illegal-opcode flag (see Optional Feature)

Behaviour:
- Instruction format: opcode = IR_in[15:12].
  - NOOP 0000.
  - STORE 0001: Ra = [11:8], addr = [7:0].
  - LOAD 0010: addr = [11:4], Rd = [3:0].
  - ADD 0011 / SUB 0100: Ra = [11:8], Rb = [7:4], Rd = [3:0].
  - HALT 0101.
- State codes (OutState): INIT 0, FETCH 1, DECODE 2, NOOP 3, LOAD_A 4, LOAD_B 5, STORE 6, ADD 7, SUB 8, HALT 9.
- Reset: at the posedge with Reset=1, state <= INIT and Illegal <= 0. While Reset=1, IR_ld, PC_up, D_wr and RF_W_en are forced 0, so an aborted instruction never writes.
- Outputs are combinational from the state and IR_in fields. Every output not listed for a state is 0.
- INIT: PC_clr=1. Next state FETCH.
- FETCH: IR_ld=1, PC_up=1. The IR captures the word at the old PC. Next state DECODE.
- DECODE: no enables asserted. Next state by opcode: NOOP, LOAD_A, STORE, ADD, SUB or HALT.
- Undefined opcodes 0110-1111 go to NOOP.
- NOOP: next state FETCH.
- STORE: RF_Ra_addr=Ra, ALU_s0=0, D_addr=addr, D_wr=1. Next state FETCH.
- LOAD_A: D_addr=addr (synchronous memory read latency). Next state LOAD_B.
- LOAD_B: D_addr=addr, RF_s=1, RF_W_addr=Rd, RF_W_en=1. Next state FETCH.
- ADD: RF_Ra_addr=Ra, RF_Rb_addr=Rb, ALU_s0=1, RF_s=0, RF_W_addr=Rd, RF_W_en=1. Next state FETCH.
- SUB: same as ADD with ALU_s0=2.
- HALT: terminal state; only Reset leaves it. PC_up and IR_ld stay 0.
- Latency, FETCH to the next FETCH: NOOP, STORE, ADD and SUB take 3 cycles; LOAD takes 4.
- IR_in is stable from DECODE through execute, because IR_ld is asserted only in FETCH.
- PC wrap-around is owned by the PC block, not this block.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN
- Defined: an undefined opcode in DECODE goes to HALT and sets Illegal=1 on that edge. Illegal holds until Reset.
- Undefined: undefined opcodes execute as NOOP, and Illegal is tied 0.

Decomposition:
- Shared package ctrl_pkg holds:
  - state_t enum with the codes above;
  - opcode localparams OP_NOOP..OP_HALT;
  - ALU select constants ALU_PASS, ALU_ADD, ALU_SUB.
- One natural sub-module: ctrl_next_state, purely combinational, computing the next state from state and opcode. controller_fsm holds the state register, the Illegal flag and the output decode.

Test Plan:
- Reset held 2 cycles then released -> OutState 0 with PC_clr=1, then 1 (IR_ld=1, PC_up=1), then 2.
- IR_in=16'h3123 -> sequence FETCH, DECODE, ADD. In ADD: RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=3, ALU_s0=1, RF_W_en=1. Back to FETCH after 3 cycles.
- IR_in=16'h20A5 -> LOAD_A then LOAD_B with D_addr=8'h0A. In LOAD_B: RF_s=1, RF_W_addr=5, RF_W_en=1. 4 cycles total.
- IR_in=16'h14C7 -> STORE with RF_Ra_addr=4, D_addr=8'hC7, D_wr=1, RF_W_en=0.
- IR_in=16'h5000 -> HALT held for 10 cycles with IR_ld=0 and PC_up=0. Then Reset -> INIT.
- IR_in=16'hF000 -> NOOP with Illegal=0 when the macro is undefined; HALT with Illegal=1 when defined. Reset asserted during an ADD cycle -> RF_W_en=0 that cycle, then INIT.
